// File: rtl/qupls4_branchmiss_arb_pkg.sv
// Shared types and constants for the branch-miss arbiter slice.
// Holds the PC/stream types, reset PC, FSM state enum and the default
// flush length used by qupls4_branchmiss_arb.
package qupls4_branchmiss_arb_pkg;

  localparam int PC_W      = 32;
  localparam int STREAM_W  = 7;
  localparam int NSTREAM   = 128;

  typedef logic [STREAM_W-1:0] pc_stream_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    pc_stream_t      stream;
  } pc_address_ex_t;

  localparam logic [PC_W-1:0] RSTPC = 32'hFFFC_0100;

  localparam int FLUSH_CYCLES_DEF = 2;

  // Streams 0 and 1 are reserved at reset (0 is never handed out, 1 is the
  // boot stream), everything else starts free.
  localparam logic [NSTREAM-1:0] FREE_MAP_RST = {{(NSTREAM-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } bm_state_e;

  // One-hot mask selecting a single stream bit in the free bitmap.
  function automatic logic [NSTREAM-1:0] stream_onehot(input pc_stream_t s);
    logic [NSTREAM-1:0] m;
    m = {{(NSTREAM-1){1'b0}}, 1'b1} << s;
    return m;
  endfunction

endpackage

// File: rtl/qupls4_branchmiss_arb_stream_alloc.sv
// Free-stream bitmap with a lowest-set-bit priority encoder.
// new_stream_o is combinational from the current bitmap; frees, returns
// and allocations all land on the bitmap at the next clock edge.
module qupls4_branchmiss_arb_stream_alloc
  import qupls4_branchmiss_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_i,
  input  logic       free_valid_i,
  input  pc_stream_t free_stream_i,
  input  logic       ret_valid_i,
  input  pc_stream_t ret_stream_i,
  output pc_stream_t new_stream_o,
  output logic       new_stream_valid_o
);

  logic [NSTREAM-1:0] bitmap_q;
  logic [NSTREAM-1:0] bitmap_d;
  pc_stream_t         lowest_s;
  logic               found_s;

  // Lowest free stream id; bit 0 is never considered allocatable.
  always_comb begin
    found_s  = 1'b0;
    lowest_s = {STREAM_W{1'b0}};
    for (int i = NSTREAM - 1; i >= 1; i--) begin
      if (bitmap_q[i]) begin
        found_s  = 1'b1;
        lowest_s = STREAM_W'(i);
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign new_stream_o       = lowest_s;
  assign new_stream_valid_o = found_s;

  // Next bitmap: releases set bits (stream 0 ignored, already-free is a no-op),
  // then an allocation clears the id currently offered.
  always_comb begin
    bitmap_d = bitmap_q;
    if (free_valid_i && (free_stream_i != {STREAM_W{1'b0}})) begin
      bitmap_d = bitmap_d | stream_onehot(free_stream_i);
    end else begin
      bitmap_d = bitmap_d;
    end
    if (ret_valid_i && (ret_stream_i != {STREAM_W{1'b0}})) begin
      bitmap_d = bitmap_d | stream_onehot(ret_stream_i);
    end else begin
      bitmap_d = bitmap_d;
    end
    if (alloc_i && found_s) begin
      bitmap_d = bitmap_d & ~stream_onehot(lowest_s);
    end else begin
      bitmap_d = bitmap_d;
    end
  end

  // Bitmap register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_q <= FREE_MAP_RST;
    end else begin
      bitmap_q <= bitmap_d;
    end
  end

endmodule

// File: rtl/qupls4_branchmiss_arb.sv
// Branch-miss arbiter: picks the oldest reporting branch unit, optionally
// allocates it a fresh stream, holds a flush for FLUSH_CYCLES cycles and then
// issues a single-cycle fetch redirect.
// Optional feature: define QUPLS4_BRANCHMISS_PREEMPT_EN to let an older miss
// pre-empt one that is still flushing.
module qupls4_branchmiss_arb
  import qupls4_branchmiss_arb_pkg::*;
#(
  parameter int NREQ         = 3,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NREQ-1:0] req_valid,
  input  pc_address_ex_t req_misspc [NREQ],
  input  logic [7:0]     req_age [NREQ],
  input  logic [NREQ-1:0] req_alloc,
  output logic [NREQ-1:0] req_ack,
  input  logic           free_valid,
  input  pc_stream_t     free_stream,
  output pc_stream_t     new_stream,
  output logic           new_stream_valid,
  output logic           flush_o,
  output logic [7:0]     flush_age,
  output logic           miss_o,
  output pc_address_ex_t misspc_o,
  output logic           stall_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam pc_address_ex_t MISSPC_RST = '{pc: RSTPC, stream: 7'd1};

  bm_state_e      state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     age_q, age_d;
  pc_address_ex_t misspc_q, misspc_d;
`ifdef QUPLS4_BRANCHMISS_PREEMPT_EN
  logic           alloc_q, alloc_d;
`endif

  logic [NREQ-1:0] elig_s;
  logic            win_found_s;
  logic [IW-1:0]   win_idx_s;
  logic [7:0]      win_age_s;
  logic            win_alloc_s;
  pc_address_ex_t  win_pc_s;
  logic            accept_ok_s;
  logic            take_s;
  logic            ret_valid_s;
  pc_stream_t      ret_stream_s;
  logic            stall_s;
  logic [NREQ-1:0] ack_s;

  qupls4_branchmiss_arb_stream_alloc u_alloc (
    .clk                (clk),
    .rst                (rst),
    .alloc_i            (take_s),
    .free_valid_i       (free_valid),
    .free_stream_i      (free_stream),
    .ret_valid_i        (ret_valid_s),
    .ret_stream_i       (ret_stream_s),
    .new_stream_o       (new_stream),
    .new_stream_valid_o (new_stream_valid)
  );

  // Which requests may compete this cycle: all in IDLE, only strictly older
  // ones during FLUSH when pre-emption is built in, none otherwise.
  always_comb begin
    elig_s = '0;
    case (state_q)
      ST_IDLE: begin
        elig_s = req_valid;
      end
      ST_FLUSH: begin
`ifdef QUPLS4_BRANCHMISS_PREEMPT_EN
        for (int i = 0; i < NREQ; i++) begin
          elig_s[i] = req_valid[i] && (req_age[i] < age_q);
        end
`else
        elig_s = '0;
`endif
      end
      default: begin
        elig_s = '0;
      end
    endcase
  end

  // Oldest eligible request; strict compare keeps ties on the lowest index.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IW{1'b0}};
    win_age_s   = 8'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (elig_s[i] && (!win_found_s || (req_age[i] < win_age_s))) begin
        win_found_s = 1'b1;
        win_idx_s   = IW'(i);
        win_age_s   = req_age[i];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign win_alloc_s = req_alloc[win_idx_s];
  assign win_pc_s    = req_misspc[win_idx_s];
  assign accept_ok_s = win_found_s && (!win_alloc_s || new_stream_valid);

  // Next-state, latch updates, ack/stall and stream pool control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    age_d        = age_q;
    misspc_d     = misspc_q;
`ifdef QUPLS4_BRANCHMISS_PREEMPT_EN
    alloc_d      = alloc_q;
`endif
    ack_s        = '0;
    take_s       = 1'b0;
    ret_valid_s  = 1'b0;
    ret_stream_s = {STREAM_W{1'b0}};
    stall_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_ok_s) begin
          ack_s[win_idx_s] = 1'b1;
          take_s           = win_alloc_s;
          age_d            = win_age_s;
          misspc_d.pc      = win_pc_s.pc;
          misspc_d.stream  = win_alloc_s ? new_stream : win_pc_s.stream;
`ifdef QUPLS4_BRANCHMISS_PREEMPT_EN
          alloc_d          = win_alloc_s;
`endif
          cnt_d            = CNT_INIT;
          state_d          = ST_FLUSH;
        end else begin
          stall_s = win_found_s;
        end
      end
      ST_FLUSH: begin
`ifdef QUPLS4_BRANCHMISS_PREEMPT_EN
        if (accept_ok_s) begin
          ack_s[win_idx_s] = 1'b1;
          take_s           = win_alloc_s;
          ret_valid_s      = alloc_q;
          ret_stream_s     = misspc_q.stream;
          age_d            = win_age_s;
          misspc_d.pc      = win_pc_s.pc;
          misspc_d.stream  = win_alloc_s ? new_stream : win_pc_s.stream;
          alloc_d          = win_alloc_s;
          cnt_d            = CNT_INIT;
          state_d          = ST_FLUSH;
        end else if (cnt_q == 4'd0) begin
          stall_s = win_found_s;
          state_d = ST_REDIRECT;
        end else begin
          stall_s = win_found_s;
          cnt_d   = cnt_q - 4'd1;
        end
`else
        if (cnt_q == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`endif
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and latched-miss registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      age_q    <= 8'd0;
      misspc_q <= MISSPC_RST;
`ifdef QUPLS4_BRANCHMISS_PREEMPT_EN
      alloc_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      age_q    <= age_d;
      misspc_q <= misspc_d;
`ifdef QUPLS4_BRANCHMISS_PREEMPT_EN
      alloc_q  <= alloc_d;
`endif
    end
  end

  assign req_ack   = ack_s;
  assign stall_o   = stall_s;
  assign flush_o   = (state_q == ST_FLUSH);
  assign flush_age = (state_q == ST_FLUSH) ? age_q : 8'd0;
  assign miss_o    = (state_q == ST_REDIRECT);
  assign misspc_o  = misspc_q;

endmodule
